// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl
//   MM:SS countdown controller for the egg timer. It takes single-cycle
//   debounced button rise pulses, sets up a time, counts it down through a
//   1 s prescaler, and then holds an alarm phase.
//
//   Ports
//     clk            system clock
//     rst            synchronous reset, active-high
//     start_rise     start/pause button pulse
//     min_rise       add-minute button pulse
//     sec_rise       add-second button pulse
//     clear_rise     clear button pulse
//     minutes [6:0]  remaining minutes, 0..MAX_MIN
//     seconds [5:0]  remaining seconds, 0..59
//     state   [2:0]  controller state (encoding in the table below)
//     running        high while counting down
//     tick           one-cycle pulse at each prescaler wrap (RUN / ALARM)
//     alarm          high while the alarm phase is active
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | 00:00, waiting for a first add-minute / add-second press
//   SET   | time being entered; start begins the countdown
//   RUN   | counting down one second per prescaler wrap
//   PAUSE | countdown frozen, prescaler phase kept for resume
//   ALARM | time expired; held for ALARM_SECS seconds or until any press
module egg_timer_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned ALARM_SECS    = 10,
   parameter int unsigned MAX_MIN       = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_rise,
   input  logic       min_rise,
   input  logic       sec_rise,
   input  logic       clear_rise,
   output logic [6:0] minutes,
   output logic [5:0] seconds,
   output logic [2:0] state,
   output logic       running,
   output logic       tick,
   output logic       alarm
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_ALARM = 3'd4
   } state_t;

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [6:0]    MIN_TOP    = 7'(MAX_MIN);
   localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_SECS);

   state_t        state_q, state_d;
   logic [6:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [AW-1:0] alarm_left_q, alarm_left_d;
   logic          tick_d;

   logic          do_clr, do_start, do_min, do_sec, any_btn, wrap;
   logic [6:0]    madd_m, sadd_m, dec_m;
   logic [5:0]    sadd_s, dec_s;
   logic          dec_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         min_q        <= '0;
         sec_q        <= '0;
         presc_q      <= '0;
         alarm_left_q <= '0;
         tick         <= 1'b0;
         running      <= 1'b0;
         alarm        <= 1'b0;
      end else begin
         state_q      <= state_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         presc_q      <= presc_d;
         alarm_left_q <= alarm_left_d;
         tick         <= tick_d;
         running      <= (state_d == S_RUN);
         alarm        <= (state_d == S_ALARM);
      end
   end

   assign minutes = min_q;
   assign seconds = sec_q;
   assign state   = state_q;

   // Button priority: clear > start > min > sec; losers in a cycle are dropped.
   always_comb begin
      do_clr   = clear_rise;
      do_start = start_rise & ~clear_rise;
      do_min   = min_rise & ~clear_rise & ~start_rise;
      do_sec   = sec_rise & ~clear_rise & ~start_rise & ~min_rise;
      any_btn  = clear_rise | start_rise | min_rise | sec_rise;
      wrap     = (presc_q == PRESC_LAST);
   end

   // Candidate time values for add-minute, add-second and decrement.
   always_comb begin
      madd_m = (min_q >= MIN_TOP) ? min_q : 7'(min_q + 7'd1);

      sadd_m = min_q;
      sadd_s = sec_q;
      if (sec_q == 6'd59) begin
         if (min_q < MIN_TOP) begin
            sadd_m = 7'(min_q + 7'd1);
            sadd_s = 6'd0;
         end
      end else begin
         sadd_s = 6'(sec_q + 6'd1);
      end

      if (sec_q == 6'd0) begin
         dec_m = 7'(min_q - 7'd1);
         dec_s = 6'd59;
      end else begin
         dec_m = min_q;
         dec_s = 6'(sec_q - 6'd1);
      end
      dec_zero = (dec_m == 7'd0) && (dec_s == 6'd0);
   end

   always_comb begin
      state_d      = state_q;
      min_d        = min_q;
      sec_d        = sec_q;
      presc_d      = presc_q;
      alarm_left_d = alarm_left_q;
      tick_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (do_min) begin
               min_d   = madd_m;
               state_d = S_SET;
            end else if (do_sec) begin
               min_d   = sadd_m;
               sec_d   = sadd_s;
               state_d = S_SET;
            end
         end

         S_SET: begin
            if (do_clr) begin
               state_d = S_IDLE;
               min_d   = '0;
               sec_d   = '0;
               presc_d = '0;
            end else if (do_start) begin
               state_d = S_RUN;
               presc_d = '0;
            end else if (do_min) begin
               min_d = madd_m;
            end else if (do_sec) begin
               min_d = sadd_m;
               sec_d = sadd_s;
            end
         end

         // start/clear take precedence over a coincident wrap, so the
         // prescaler is neither advanced nor wrapped on those edges.
         S_RUN: begin
            if (do_clr) begin
               state_d = S_IDLE;
               min_d   = '0;
               sec_d   = '0;
               presc_d = '0;
            end else if (do_start) begin
               state_d = S_PAUSE;
            end else if (wrap) begin
               presc_d = '0;
               tick_d  = 1'b1;
               min_d   = dec_m;
               sec_d   = dec_s;
               if (dec_zero) begin
                  state_d      = S_ALARM;
                  alarm_left_d = ALARM_LOAD;
               end
            end else begin
               presc_d = PW'(presc_q + PW'(1));
            end
         end

         S_PAUSE: begin
            if (do_clr) begin
               state_d = S_IDLE;
               min_d   = '0;
               sec_d   = '0;
               presc_d = '0;
            end else if (do_start) begin
               state_d = S_RUN;
            end
         end

         S_ALARM: begin
            if (any_btn) begin
               state_d = S_IDLE;
               presc_d = '0;
            end else if (wrap) begin
               presc_d = '0;
               tick_d  = 1'b1;
               // ALARM_SECS == 0 keeps the alarm until a button is pressed.
               if (ALARM_SECS != 0) begin
                  if (alarm_left_q == AW'(1)) begin
                     state_d = S_IDLE;
                  end else begin
                     alarm_left_d = AW'(alarm_left_q - AW'(1));
                  end
               end
            end else begin
               presc_d = PW'(presc_q + PW'(1));
            end
         end

         default: begin
            state_d = S_IDLE;
            min_d   = '0;
            sec_d   = '0;
            presc_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Testbench for egg_timer_ctrl with TICKS_PER_SEC=4, ALARM_SECS=2, MAX_MIN=99.
// A reference model tracks the time as a single count of seconds and the
// prescaler as a phase number; every cycle the DUT is compared against it,
// and table rows / directed sequences add fixed expectations on top.
module tb_egg_timer_ctrl;

   localparam int TPS = 4;
   localparam int AS  = 2;
   localparam int MX  = 99;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_rise = 1'b0, min_rise = 1'b0, sec_rise = 1'b0, clear_rise = 1'b0;
   logic [6:0] minutes;
   logic [5:0] seconds;
   logic [2:0] state;
   logic       running, tick, alarm;

   egg_timer_ctrl #(
      .TICKS_PER_SEC (TPS),
      .ALARM_SECS    (AS),
      .MAX_MIN       (MX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_rise (start_rise),
      .min_rise   (min_rise),
      .sec_rise   (sec_rise),
      .clear_rise (clear_rise),
      .minutes    (minutes),
      .seconds    (seconds),
      .state      (state),
      .running    (running),
      .tick       (tick),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: 0 IDLE, 1 SET, 2 RUN, 3 PAUSE, 4 ALARM; time in seconds
   int m_st = 0, m_t = 0, m_ph = 0, m_secs_in_alarm = 0;
   bit m_tick = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic add_min();
      if (m_t / 60 < MX) m_t += 60;
   endtask

   task automatic add_sec();
      if (m_t < MX * 60 + 59) m_t += 1;
   endtask

   task automatic model_step(input bit r, input bit s, input bit mi, input bit se, input bit c);
      bit ps, pm, pse, wr;
      m_tick = 0;
      if (r) begin
         m_st = 0; m_t = 0; m_ph = 0; m_secs_in_alarm = 0;
      end else begin
         ps  = s & !c;
         pm  = mi & !c & !s;
         pse = se & !c & !s & !mi;
         wr  = (m_ph == TPS - 1);
         case (m_st)
            0: begin
               if (pm) begin add_min(); m_st = 1; end
               else if (pse) begin add_sec(); m_st = 1; end
            end
            1: begin
               if (c) begin m_st = 0; m_t = 0; m_ph = 0; end
               else if (ps) begin m_st = 2; m_ph = 0; end
               else if (pm) add_min();
               else if (pse) add_sec();
            end
            2: begin
               if (c) begin m_st = 0; m_t = 0; m_ph = 0; end
               else if (ps) m_st = 3;
               else if (wr) begin
                  m_ph = 0; m_tick = 1; m_t -= 1;
                  if (m_t == 0) begin m_st = 4; m_secs_in_alarm = 0; end
               end else m_ph++;
            end
            3: begin
               if (c) begin m_st = 0; m_t = 0; m_ph = 0; end
               else if (ps) m_st = 2;
            end
            default: begin
               if (c | s | mi | se) begin m_st = 0; m_ph = 0; end
               else if (wr) begin
                  m_ph = 0; m_tick = 1; m_secs_in_alarm++;
                  if (AS != 0 && m_secs_in_alarm == AS) m_st = 0;
               end else m_ph++;
            end
         endcase
      end
   endtask

   task automatic step(input bit r, input bit s, input bit mi, input bit se, input bit c);
      rst = r; start_rise = s; min_rise = mi; sec_rise = se; clear_rise = c;
      model_step(r, s, mi, se, c);
      @(posedge clk);
      #1;
      chk("m_state",   int'(state),   m_st);
      chk("m_minutes", int'(minutes), m_t / 60);
      chk("m_seconds", int'(seconds), m_t % 60);
      chk("m_running", int'(running), int'(m_st == 2));
      chk("m_alarm",   int'(alarm),   int'(m_st == 4));
      chk("m_tick",    int'(tick),    int'(m_tick));
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit r, s, mi, se, c;
      int st, mn, sc, al, tk;
   } vec_t;
   vec_t tbl[$];

   function automatic void addv(bit r, bit s, bit mi, bit se, bit c,
                                int st, int mn, int sc, int al, int tk);
      vec_t v;
      v.r = r; v.s = s; v.mi = mi; v.se = se; v.c = c;
      v.st = st; v.mn = mn; v.sc = sc; v.al = al; v.tk = tk;
      tbl.push_back(v);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset, ignored start, set 00:03, run it down to ALARM
      addv(1,0,0,0,0, 0,0,0,0,0);
      addv(0,1,0,0,0, 0,0,0,0,0);
      addv(0,0,0,1,0, 1,0,1,0,0);
      addv(0,0,0,1,0, 1,0,2,0,0);
      addv(0,0,0,1,0, 1,0,3,0,0);
      addv(0,1,0,0,0, 2,0,3,0,0);
      for (int s = 2; s >= 0; s--) begin
         for (int k = 0; k < 3; k++) addv(0,0,0,0,0, 2,0,s+1,0,0);
         if (s == 0) addv(0,0,0,0,0, 4,0,0,1,1);
         else        addv(0,0,0,0,0, 2,0,s,0,1);
      end

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].mi, tbl[i].se, tbl[i].c);
         chk($sformatf("tbl%0d_state", i),   int'(state),   tbl[i].st);
         chk($sformatf("tbl%0d_minutes", i), int'(minutes), tbl[i].mn);
         chk($sformatf("tbl%0d_seconds", i), int'(seconds), tbl[i].sc);
         chk($sformatf("tbl%0d_alarm", i),   int'(alarm),   tbl[i].al);
         chk($sformatf("tbl%0d_tick", i),    int'(tick),    tbl[i].tk);
      end

      // unattended alarm times out after 2 seconds = 8 clk
      for (int i = 1; i <= 8; i++) begin
         nop();
         chk($sformatf("alarm_to%0d_state", i), int'(state), (i == 8) ? 0 : 4);
         chk($sformatf("alarm_to%0d_tick", i),  int'(tick),  (i == 4 || i == 8) ? 1 : 0);
      end

      // seconds carry and saturation at 99:59
      for (int i = 0; i < 59; i++) step(0,0,0,1,0);
      chk("set_0059_sec", int'(seconds), 59);
      step(0,0,0,1,0);
      chk("carry_min", int'(minutes), 1);
      chk("carry_sec", int'(seconds), 0);
      step(0,0,0,0,1);
      chk("clear_state", int'(state), 0);
      for (int i = 0; i < 100; i++) step(0,0,1,0,0);
      chk("min_sat", int'(minutes), 99);
      for (int i = 0; i < 59; i++) step(0,0,0,1,0);
      step(0,0,1,0,0);
      chk("top_min_after_min", int'(minutes), 99);
      chk("top_sec_after_min", int'(seconds), 59);
      step(0,0,0,1,0);
      chk("top_min_after_sec", int'(minutes), 99);
      chk("top_sec_after_sec", int'(seconds), 59);
      step(0,0,0,0,1);

      // pause at prescaler phase 2, resume, first tick two clocks later
      for (int i = 0; i < 5; i++) step(0,0,0,1,0);
      step(0,1,0,0,0);
      nop(); nop();
      step(0,1,0,0,0);
      chk("pause_state", int'(state), 3);
      for (int i = 0; i < 20; i++) nop();
      chk("pause_frozen_sec", int'(seconds), 5);
      chk("pause_frozen_state", int'(state), 3);
      step(0,1,0,0,0);
      chk("resume_state", int'(state), 2);
      nop();
      chk("resume_tick1", int'(tick), 0);
      nop();
      chk("resume_tick2", int'(tick), 1);
      chk("resume_sec", int'(seconds), 4);

      // clear beats start in RUN
      step(0,1,0,0,1);
      chk("clr_start_state", int'(state), 0);
      chk("clr_start_sec", int'(seconds), 0);

      // start coincident with a wrap drops the decrement
      for (int i = 0; i < 3; i++) step(0,0,0,1,0);
      step(0,1,0,0,0);
      nop(); nop(); nop();
      step(0,1,0,0,0);
      chk("start_on_tick_state", int'(state), 3);
      chk("start_on_tick_sec", int'(seconds), 3);
      chk("start_on_tick_tick", int'(tick), 0);

      // resume and run into a second alarm, then acknowledge with min
      step(0,1,0,0,0);
      for (int i = 0; i < 40 && state != 3'd4; i++) nop();
      chk("second_alarm", int'(state), 4);
      step(0,0,1,0,0);
      chk("ack_state", int'(state), 0);
      chk("ack_min", int'(minutes), 0);
      chk("ack_sec", int'(seconds), 0);
      chk("ack_alarm", int'(alarm), 0);

      // reset mid-RUN
      step(0,0,0,1,0);
      step(0,1,0,0,0);
      nop(); nop(); nop();
      step(1,0,0,0,0);
      chk("rst_run_state", int'(state), 0);
      chk("rst_run_sec", int'(seconds), 0);
      chk("rst_run_running", int'(running), 0);
      step(1,1,1,1,0);
      chk("rst_beats_btn", int'(state), 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 499) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 39) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
